mem_ctrl_arb: RTL and testbench
===============================

Name: mem_ctrl_arb

Overview:
- Memory controller that answers the instruction-fetch unit's byte requests and the MEM stage's load/store requests, over one shared byte-wide synchronous RAM port.
- IF traffic is a one-byte-per-cycle pass-through.
- MEM traffic is a multi-byte sequenced transaction with priority over IF. During a MEM transaction, IF is frozen through the stall controller.

Parameters:
ADDR_W, 17, number of RAM address bits driven; the internal 32-bit address is truncated to ADDR_W.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
rdy  in  1  chip ready; low freezes all state
if_request_i  in  1  IF wants a byte this cycle
if_addr_i  in  32  IF byte address
mem_request_i  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
mem_width_i  in  2  00 byte, 01 half, 10/11 word
mem_addr_i  in  32  MEM base byte address
mem_wdata_i  in  32  store data, little-endian
mem_rdata_o  out  32  load result, zero-extended
mem_done_o  out  1  one-cycle completion pulse
stall_req_o  out  1  to ctrl; source of IF stall bit
mem_ctrl_data_o  out  8  returned byte (IF or MEM)
if_or_mem_o  out  2  01 byte on mem_ctrl_data_o is IF's, 10 MEM's, 00 none
ram_a_o  out  ADDR_W  RAM address
ram_dout_o  out  8  RAM write data
ram_wr_o  out  1  RAM write enable
ram_din_i  in  8  RAM read data, valid one cycle after address

Behaviour:
- Reset (rst=0, async):
  - state IDLE; byte counter 0.
  - All registered outputs 0: mem_rdata_o, mem_done_o, if_or_mem_o.
  - ram_wr_o 0.
  - A transaction in flight is aborted: no done pulse, no further writes.
- rdy=0: state, counter and registers hold; ram_wr_o forced 0.
- mem_ctrl_data_o = ram_din_i, combinational.
- if_or_mem_o is a registered copy of last cycle's bus owner (01 IF read, 10 MEM read, 00 idle or write).
- IDLE, mem_request_i==00:
  - ram_a_o = if_addr_i[ADDR_W-1:0], combinational; ram_wr_o 0.
  - Byte for an address driven in cycle n is on mem_ctrl_data_o in cycle n+1, tagged 01 if if_request_i was 1 in cycle n.
  - stall_req_o 0.
- IDLE, mem_request_i!=00:
  - stall_req_o=1 combinationally in the same cycle.
  - Bus is taken by MEM this cycle; byte count N=1/2/4 from mem_width_i.
  - Go to LOAD or STORE with cnt=0; byte 0 is issued this cycle.
  - The IF request in that cycle is dropped; IF re-issues via its stall-recovery path.
- LOAD:
  - Each cycle: ram_a_o = mem_addr_i+cnt, computed 32-bit, wraps, then truncated.
  - Byte returned in cycle k is placed into mem_rdata_o[8k+7:8k].
  - After the address for byte N-1, one extra cycle captures the last byte; go to DONE.
  - Total: N+1 cycles from request to DONE.
- STORE:
  - Each cycle: ram_wr_o=1, ram_a_o = mem_addr_i+cnt, ram_dout_o = mem_wdata_i[8cnt+7:8cnt].
  - After byte N-1 is written, go to DONE. Total N cycles.
- stall_req_o=1 in LOAD/STORE, 0 in DONE.
- DONE (1 cycle):
  - mem_done_o=1; mem_rdata_o stable (upper bytes 0 for byte/half).
  - Bus returns to IF pass-through this cycle.
  - mem_request_i is ignored; the MEM stage must deassert it this cycle.
  - Next state IDLE.
- mem_rdata_o is cleared at the start of each load and holds after DONE until the next load.
- mem_request_i, mem_addr_i, mem_width_i and mem_wdata_i must stay stable from acceptance through DONE.

Optional Feature:
- Macro IO_BUFFER_FULL_EN adds input io_buffer_full_i (1 bit).
- With the macro: a store byte whose address has bits [17:16]==2'b11 is held while io_buffer_full_i=1.
  - Held means ram_wr_o=0, cnt holds, stall_req_o stays 1.
  - The byte is written in the first cycle io_buffer_full_i=0.
- Without the macro: no such port; stores never wait.

Test Plan:
- IF stream: IDLE, if_addr_i=0x0,0x1,0x2,0x3 on consecutive cycles → ram_a_o follows same cycle; mem_ctrl_data_o = RAM[0..3] one cycle later; if_or_mem_o=01 each.
- Word load: RAM[0x100..0x103]=11,22,33,44; mem_request_i=01, width=10, addr=0x100 → stall_req_o=1 immediately; done pulse 5 cycles later; mem_rdata_o=0x44332211; stall_req_o=0 in done cycle.
- Half store: mem_request_i=10, width=01, addr=0x1FF, wdata=0xAABBCCDD → RAM[0x1FF]=DD, RAM[0x200]=CC; exactly 2 ram_wr_o cycles; done on cycle 3.
- Wrap: byte load at addr=0xFFFFFFFF with ADDR_W=17 → ram_a_o=0x1FFFF; mem_rdata_o=0x000000 | RAM[0x1FFFF].
- Reset mid-store: rst low after byte 1 of a word store → ram_wr_o 0 at once; no mem_done_o; RAM bytes 2,3 unchanged.
- IO_BUFFER_FULL_EN: byte store to 0x30000 with io_buffer_full_i=1 for 3 cycles → no write for 3 cycles; write on 4th; done next cycle.

Source files
------------

// File: rtl/mem_ctrl_arb.sv
// Shared byte-wide RAM port arbiter: IF byte pass-through plus sequenced MEM load/store (MEM wins).
// Latency: IF byte 1 cycle; load N+1 cycles to DONE, store N cycles; rdy=0 freezes; stall_req_o holds IF.
// Optional IO_BUFFER_FULL_EN: stores to addr[17:16]==2'b11 wait while io_buffer_full_i is high.
module mem_ctrl_arb #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_request_i,
    input  logic [31:0]       if_addr_i,
    input  logic [1:0]        mem_request_i,
    input  logic [1:0]        mem_width_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic              stall_req_o,
    output logic [7:0]        mem_ctrl_data_o,
    output logic [1:0]        if_or_mem_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic [7:0]        ram_dout_o,
    output logic              ram_wr_o,
    input  logic [7:0]        ram_din_i
`ifdef IO_BUFFER_FULL_EN
    ,
    input  logic              io_buffer_full_i
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_DONE} state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_done;
    logic [1:0]  r_owner;

    logic        w_req_ld;
    logic        w_req_st;
    logic        w_accept;
    logic        w_mem_bus;
    logic        w_is_store;
    logic        w_hold;
    logic        w_issue_ld;
    logic        w_wr;
    logic [2:0]  w_n;
    logic [2:0]  w_idx;
    logic [31:0] w_addr32;
    logic        w_unused;

    assign w_req_ld   = (mem_request_i == 2'b01);
    assign w_req_st   = (mem_request_i == 2'b10);
    assign w_accept   = (r_state == S_IDLE) && (w_req_ld || w_req_st);
    assign w_mem_bus  = w_accept || (r_state == S_LOAD) || (r_state == S_STORE);
    assign w_is_store = (w_accept && w_req_st) || (r_state == S_STORE);

    always_comb begin
        case (mem_width_i)
            2'b00:   w_n = 3'd1;
            2'b01:   w_n = 3'd2;
            default: w_n = 3'd4;
        endcase
    end

    // r_cnt holds the index of the next byte to issue; the accept cycle issues byte 0 itself.
    assign w_idx    = (r_state == S_IDLE) ? 3'd0 : r_cnt;
    assign w_addr32 = mem_addr_i + {29'd0, w_idx};

`ifdef IO_BUFFER_FULL_EN
    assign w_hold = w_is_store && (w_addr32[17:16] == 2'b11) && io_buffer_full_i;
`else
    assign w_hold = 1'b0;
`endif

    assign w_issue_ld = (w_accept && w_req_ld) || ((r_state == S_LOAD) && (r_cnt < w_n));
    assign w_wr       = w_is_store && !w_hold;

    assign ram_a_o         = w_mem_bus ? w_addr32[ADDR_W-1:0] : if_addr_i[ADDR_W-1:0];
    assign ram_wr_o        = w_wr && rdy && rst;
    assign stall_req_o     = w_mem_bus;
    assign mem_ctrl_data_o = ram_din_i;
    assign mem_rdata_o     = r_rdata;
    assign mem_done_o      = r_done;
    assign if_or_mem_o     = r_owner;
    assign w_unused        = ^{if_addr_i[31:ADDR_W], w_addr32[31:ADDR_W]};

    always_comb begin
        case (w_idx[1:0])
            2'd0:    ram_dout_o = mem_wdata_i[7:0];
            2'd1:    ram_dout_o = mem_wdata_i[15:8];
            2'd2:    ram_dout_o = mem_wdata_i[23:16];
            default: ram_dout_o = mem_wdata_i[31:24];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_rdata <= 32'd0;
            r_done  <= 1'b0;
            r_owner <= 2'b00;
        end else if (rdy) begin
            r_done <= 1'b0;
            if (w_issue_ld)
                r_owner <= 2'b10;
            else if (!w_mem_bus && if_request_i)
                r_owner <= 2'b01;
            else
                r_owner <= 2'b00;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_req_ld) begin
                            r_rdata <= 32'd0;
                            r_cnt   <= 3'd1;
                            r_state <= S_LOAD;
                        end else if (w_hold) begin
                            r_cnt   <= 3'd0;
                            r_state <= S_STORE;
                        end else if (w_n == 3'd1) begin
                            r_cnt   <= 3'd0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt   <= 3'd1;
                            r_state <= S_STORE;
                        end
                    end
                end
                S_LOAD: begin
                    // RAM data lags the address by a cycle, so this captures byte r_cnt-1.
                    case (r_cnt)
                        3'd1:    r_rdata[7:0]   <= ram_din_i;
                        3'd2:    r_rdata[15:8]  <= ram_din_i;
                        3'd3:    r_rdata[23:16] <= ram_din_i;
                        default: r_rdata[31:24] <= ram_din_i;
                    endcase
                    if (r_cnt == w_n) begin
                        r_cnt   <= 3'd0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_STORE: begin
                    if (!w_hold) begin
                        if (r_cnt == w_n - 3'd1) begin
                            r_cnt   <= 3'd0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Scoreboarded bench for mem_ctrl_arb: stimulus pushes expected writes/bytes/done events, a monitor pops them.
module tb_mem_ctrl_arb;
    localparam int ADDR_W = 17;
    localparam int MEM_SZ = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              rdy;
    logic              if_request_i;
    logic [31:0]       if_addr_i;
    logic [1:0]        mem_request_i;
    logic [1:0]        mem_width_i;
    logic [31:0]       mem_addr_i;
    logic [31:0]       mem_wdata_i;
    logic [31:0]       mem_rdata_o;
    logic              mem_done_o;
    logic              stall_req_o;
    logic [7:0]        mem_ctrl_data_o;
    logic [1:0]        if_or_mem_o;
    logic [ADDR_W-1:0] ram_a_o;
    logic [7:0]        ram_dout_o;
    logic              ram_wr_o;
    logic [7:0]        ram_din_i;
`ifdef IO_BUFFER_FULL_EN
    logic              io_buffer_full_i;
`endif

    mem_ctrl_arb #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_request_i(if_request_i), .if_addr_i(if_addr_i),
        .mem_request_i(mem_request_i), .mem_width_i(mem_width_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o), .stall_req_o(stall_req_o),
        .mem_ctrl_data_o(mem_ctrl_data_o), .if_or_mem_o(if_or_mem_o),
        .ram_a_o(ram_a_o), .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o), .ram_din_i(ram_din_i)
`ifdef IO_BUFFER_FULL_EN
        , .io_buffer_full_i(io_buffer_full_i)
`endif
    );

    typedef struct { logic [ADDR_W-1:0] a; logic [7:0] d; } wr_t;
    typedef struct { int cyc; logic [31:0] val; } done_t;

    logic [7:0]  ram     [MEM_SZ];
    logic [7:0]  ref_mem [MEM_SZ];
    wr_t         wr_q[$];
    logic [7:0]  if_q[$];
    done_t       done_q[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_load = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_wr_o) ram[ram_a_o] <= ram_dout_o;
        ram_din_i <= ram[ram_a_o];
    end

    function automatic logic [ADDR_W-1:0] trunc(input logic [31:0] a);
        return a[ADDR_W-1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got an event, expected none (cycle %0d)", name, cyc);
    endtask

    // Monitor: every DUT-presented event must match the oldest pending expectation.
    always @(negedge clk) begin
        if (ram_wr_o) begin
            if (wr_q.size() == 0) unexpected("ram_write");
            else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("wr_addr", 32'(ram_a_o), 32'(e.a));
                chk("wr_data", 32'(ram_dout_o), 32'(e.d));
            end
        end
        if (if_or_mem_o == 2'b01) begin
            if (if_q.size() == 0) unexpected("if_byte_tag");
            else chk("if_byte", 32'(mem_ctrl_data_o), 32'(if_q.pop_front()));
        end
        if (mem_done_o) begin
            if (done_q.size() == 0) unexpected("mem_done");
            else begin
                done_t d;
                d = done_q.pop_front();
                chk("done_cycle", cyc, d.cyc);
                chk("done_rdata", mem_rdata_o, d.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic if_read(input logic [31:0] addr, input logic req);
        step();
        mem_request_i = 2'b00;
        if_request_i  = req;
        if_addr_i     = addr;
        if (req) if_q.push_back(ref_mem[trunc(addr)]);
        #1;
        chk("if_ram_a", 32'(ram_a_o), 32'(trunc(addr)));
    endtask

    task automatic mem_op(input bit st, input logic [1:0] w, input logic [31:0] addr,
                          input logic [31:0] wd, input int holds);
        int          n;
        int          c0;
        int          dc;
        logic [31:0] val;
        n = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
        step();
        c0            = cyc;
        rdy           = 1'b1;
        mem_request_i = st ? 2'b10 : 2'b01;
        mem_width_i   = w;
        mem_addr_i    = addr;
        mem_wdata_i   = wd;
        if_request_i  = 1'($urandom_range(0, 1));
        if_addr_i     = $urandom;
`ifdef IO_BUFFER_FULL_EN
        io_buffer_full_i = (holds > 0);
`endif
        if (st) begin
            for (int k = 0; k < n; k++) begin
                wr_q.push_back('{a: trunc(addr + 32'(k)), d: wd[8*k +: 8]});
                ref_mem[trunc(addr + 32'(k))] = wd[8*k +: 8];
            end
            val = last_load;
            dc  = c0 + n + holds;
        end else begin
            val = 32'd0;
            for (int k = 0; k < n; k++)
                val = val | (32'(ref_mem[trunc(addr + 32'(k))]) << (8*k));
            last_load = val;
            dc = c0 + n + 1;
        end
        done_q.push_back('{cyc: dc, val: val});
        #1;
        chk("stall_on_req", 32'(stall_req_o), 32'd1);
        chk("mem_ram_a", 32'(ram_a_o), 32'(trunc(addr)));
        for (int i = 1; i < dc - c0; i++) begin
            step();
            if_request_i = 1'($urandom_range(0, 1));
            if_addr_i    = $urandom;
`ifdef IO_BUFFER_FULL_EN
            io_buffer_full_i = (i < holds);
`endif
            #1;
            chk("stall_busy", 32'(stall_req_o), 32'd1);
        end
        step();
        mem_request_i = 2'b00;
        if_request_i  = 1'($urandom_range(0, 1));
        if_addr_i     = $urandom;
`ifdef IO_BUFFER_FULL_EN
        io_buffer_full_i = 1'b0;
`endif
        if (if_request_i) if_q.push_back(ref_mem[trunc(if_addr_i)]);
        #1;
        chk("stall_done", 32'(stall_req_o), 32'd0);
        chk("done_ram_a", 32'(ram_a_o), 32'(trunc(if_addr_i)));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          kind;
        int          burst;
        int          diffs;
        logic [31:0] a;
        logic [7:0]  b;

        rst = 1'b0; rdy = 1'b1; if_request_i = 1'b0; if_addr_i = 32'd0;
        mem_request_i = 2'b00; mem_width_i = 2'b00; mem_addr_i = 32'd0; mem_wdata_i = 32'd0;
`ifdef IO_BUFFER_FULL_EN
        io_buffer_full_i = 1'b0;
`endif
        for (int i = 0; i < MEM_SZ; i++) begin
            b = 8'($urandom);
            ram[i] = b;
            ref_mem[i] = b;
        end
        ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
        ref_mem[32'h100] = 8'h11; ref_mem[32'h101] = 8'h22; ref_mem[32'h102] = 8'h33; ref_mem[32'h103] = 8'h44;

        step(); step();
        chk("reset_rdata", mem_rdata_o, 32'd0);
        chk("reset_done", 32'(mem_done_o), 32'd0);
        chk("reset_owner", 32'(if_or_mem_o), 32'd0);
        chk("reset_wr", 32'(ram_wr_o), 32'd0);
        chk("reset_stall", 32'(stall_req_o), 32'd0);
        step();
        rst = 1'b1;

        for (int i = 0; i < 4; i++) if_read(32'(i), 1'b1);
        if_read(32'h0, 1'b0);

        mem_op(1'b0, 2'b10, 32'h100, 32'h0, 0);
        chk("word_load_value", mem_rdata_o, 32'h44332211);
        mem_op(1'b1, 2'b01, 32'h1FF, 32'hAABBCCDD, 0);
        mem_op(1'b0, 2'b00, 32'hFFFF_FFFF, 32'h0, 0);
        if_read(32'h1FF, 1'b1);
        if_read(32'h200, 1'b1);

        // rdy low with a store pending: nothing may move or be written.
        if_read(32'h0, 1'b0);
        step();
        rdy = 1'b0; mem_request_i = 2'b10; mem_width_i = 2'b00;
        mem_addr_i = 32'h555; mem_wdata_i = 32'h5A;
        #1;
        chk("rdy_low_no_wr", 32'(ram_wr_o), 32'd0);
        step();
        chk("rdy_low_no_wr2", 32'(ram_wr_o), 32'd0);
        chk("rdy_low_no_done", 32'(mem_done_o), 32'd0);
        mem_op(1'b1, 2'b00, 32'h555, 32'h5A, 0);

        // Reset lands after byte 1 of a word store.
        step();
        mem_request_i = 2'b10; mem_width_i = 2'b10; mem_addr_i = 32'h2345;
        mem_wdata_i = 32'h01020304; if_request_i = 1'b0;
        wr_q.push_back('{a: trunc(32'h2345), d: 8'h04});
        ref_mem[trunc(32'h2345)] = 8'h04;
        step();
        wr_q.push_back('{a: trunc(32'h2346), d: 8'h03});
        ref_mem[trunc(32'h2346)] = 8'h03;
        step();
        rst = 1'b0;
        #1;
        chk("reset_abort_wr", 32'(ram_wr_o), 32'd0);
        chk("reset_abort_done", 32'(mem_done_o), 32'd0);
        chk("reset_abort_owner", 32'(if_or_mem_o), 32'd0);
        mem_request_i = 2'b00;
        last_load = 32'd0;
        step(); step();
        rst = 1'b1;
        mem_op(1'b1, 2'b00, 32'h9, 32'h77, 0);

`ifdef IO_BUFFER_FULL_EN
        mem_op(1'b1, 2'b00, 32'h30000, 32'hE7, 3);
`endif

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 2);
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            if (kind == 0) begin
                burst = $urandom_range(1, 4);
                for (int j = 0; j < burst; j++) if_read($urandom, 1'($urandom_range(0, 1)));
            end else begin
                mem_op(kind == 2, 2'($urandom_range(0, 3)), a, $urandom, 0);
            end
        end

        if_read(32'h0, 1'b0);
        step(); step();
        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
        chk("if_q_drained", 32'(if_q.size()), 32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);
        diffs = 0;
        for (int i = 0; i < MEM_SZ; i++) if (ram[i] !== ref_mem[i]) diffs++;
        chk("ram_image_diffs", diffs, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
